// File: rtl/iob_en_reg.sv
// Enabled data register with two synchronous active-high resets.
// Used as a software-register backing store; output comes straight from the flops.
module iob_en_reg #(
  parameter int unsigned          DATA_W  = 32,
  parameter logic [DATA_W-1:0]    RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic              w_rst;
  logic [DATA_W-1:0] r_data;

  // arst keeps its legacy name but is sampled on clk like rst
  assign w_rst = arst | rst;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_data <= RST_VAL;
    end else if (en) begin
      r_data <= data_in;
    end
  end

  assign data_out = r_data;

endmodule

// File: tb/tb_iob_en_reg.sv
// Scoreboard bench for iob_en_reg: a 32-bit default instance and an 8-bit
// instance with RST_VAL=8'h3C share stimulus; a monitor pops expected values.
module tb_iob_en_reg;

  logic        clk = 1'b0;
  logic        arst;
  logic        rst;
  logic        en;
  logic [31:0] data_in;
  logic [31:0] dout32;
  logic [7:0]  dout8;

  always #5 clk = ~clk;

  iob_en_reg iob_reg (
    .clk      (clk),
    .arst     (arst),
    .rst      (rst),
    .en       (en),
    .data_in  (data_in),
    .data_out (dout32)
  );

  iob_en_reg #(.DATA_W(8), .RST_VAL(8'h3C)) iob_reg8 (
    .clk      (clk),
    .arst     (arst),
    .rst      (rst),
    .en       (en),
    .data_in  (data_in[7:0]),
    .data_out (dout8)
  );

  typedef struct {
    logic [31:0] e32;
    logic [7:0]  e8;
    string       tag;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] m32;
  logic [7:0]  m8;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference: reset wins, else enable loads, else the register keeps its value
  task automatic step(input logic r, input logic ar, input logic e,
                      input logic [31:0] d, input string tag);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; arst = ar; en = e; data_in = d;
    if (r || ar) begin
      m32 = 32'h0;
      m8  = 8'h3C;
    end else if (e) begin
      m32 = d;
      m8  = d[7:0];
    end
    x.e32 = m32;
    x.e8  = m8;
    x.tag = tag;
    q.push_back(x);
  endtask

  // Monitor: one result per clock edge, sampled on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      n_checks++;
      if (dout32 === cur.e32) n_pass++;
      else $display("FAIL %s w32: got %h expected %h", cur.tag, dout32, cur.e32);
      n_checks++;
      if (dout8 === cur.e8) n_pass++;
      else $display("FAIL %s w8: got %h expected %h", cur.tag, dout8, cur.e8);
    end
  end

  initial begin
    rst = 1'b1; arst = 1'b0; en = 1'b0; data_in = 32'h0;

    step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, "rst_en");
    step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, "rst_en");
    step(1'b0, 1'b0, 1'b1, 32'h11111111, "load_between");
    step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, "arst_en");
    step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, "arst_en");
    step(1'b1, 1'b1, 1'b0, 32'h0,        "both_rst");

    step(1'b0, 1'b0, 1'b1, 32'h12345678, "load");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, "hold");
    step(1'b0, 1'b0, 1'b0, 'x, "hold_x");

    step(1'b0, 1'b0, 1'b1, 32'd1, "b2b1");
    step(1'b0, 1'b0, 1'b1, 32'd2, "b2b2");
    step(1'b0, 1'b0, 1'b1, 32'd3, "b2b3");

    step(1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, "pre_prio");
    step(1'b1, 1'b0, 1'b1, 32'h5A5A5A5A, "rst_prio");
    step(1'b0, 1'b0, 1'b1, 32'h5A5A5A5A, "post_rst_load");

    step(1'b1, 1'b0, 1'b0, 32'h0,        "p8_rst");
    step(1'b0, 1'b0, 1'b1, 32'h000000FF, "p8_load");
    step(1'b0, 1'b0, 1'b0, 32'h00000000, "p8_hold");
    step(1'b0, 1'b1, 1'b0, 32'h0,        "p8_rst2");

    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), $urandom, "random");
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
